// File: rtl/fp_add_sub_pipe.sv
// Three-stage floating-point add/subtract: align, add magnitudes, normalise/round/pack.
// Round to nearest even, gradual underflow, one stall enable shared by all stages.
module fp_add_sub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_add,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [2:0]   flags
);
    localparam int MW = MAN_W + 4;        // {hidden, frac, guard, round, sticky}
    localparam int SW = MAN_W + 5;        // MW plus carry out
    localparam int XW = 2 * MAN_W + 4;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [31:0] SHIFT_LIM = 32'(MAN_W + 3);

    // Handshake: a transfer happens on a cycle where valid and ready are both 1;
    // every stage register moves only when the output is empty or being taken.
    logic en;

    logic             s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q;
    logic             s1_special_d, s1_special_q;
    logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
    logic [MW-1:0]    s1_mx_d, s1_mx_q, s1_my_d, s1_my_q;
    logic [W-1:0]     s1_spec_res_d, s1_spec_res_q;
    logic [2:0]       s1_spec_flags_d, s1_spec_flags_q;

    logic             s2_valid_d, s2_valid_q, s2_sign_d, s2_sign_q, s2_sub_d, s2_sub_q;
    logic             s2_special_d, s2_special_q;
    logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
    logic [SW-1:0]    s2_sum_d, s2_sum_q;
    logic [W-1:0]     s2_spec_res_d, s2_spec_res_q;
    logic [2:0]       s2_spec_flags_d, s2_spec_flags_q;

    logic             out_valid_d, out_valid_q;
    logic [W-1:0]     result_d, result_q;
    logic [2:0]       flags_d, flags_q;

    assign en        = out_ready | ~out_valid_q;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    logic             a_sign, b_sign, b_sign_eff;
    logic [EXP_W-1:0] a_exp, b_exp, x_exp, y_exp, shift;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic [MAN_W:0]   x_mant, y_mant;
    logic [XW-1:0]    y_wide;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;

    assign {a_sign, a_exp, a_frac} = a;
    assign {b_sign, b_exp, b_frac} = b;

    always_comb begin
        b_sign_eff = b_sign ^ ~op_add;
        a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
        b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
        a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
        b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
        a_snan = a_nan && !a_frac[MAN_W-1];
        b_snan = b_nan && !b_frac[MAN_W-1];
        swap   = {b_exp, b_frac} > {a_exp, a_frac};
        x_exp  = swap ? b_exp : a_exp;
        y_exp  = swap ? a_exp : b_exp;
        x_mant = swap ? {b_exp != '0, b_frac} : {a_exp != '0, a_frac};
        y_mant = swap ? {a_exp != '0, a_frac} : {b_exp != '0, b_frac};
        // Subnormals act as exponent 1 with a zero hidden bit.
        s1_exp_d = (x_exp == '0) ? EXP_W'(1) : x_exp;
        shift    = s1_exp_d - ((y_exp == '0) ? EXP_W'(1) : y_exp);
        y_wide   = {y_mant, {(MAN_W+3){1'b0}}} >> shift;
        if (32'(shift) >= SHIFT_LIM) s1_my_d = {{(MW-1){1'b0}}, |y_mant};
        else                         s1_my_d = {y_wide[XW-1 -: MAN_W+3], |y_wide[MAN_W:0]};
        s1_mx_d    = {x_mant, 3'b000};
        s1_sign_d  = swap ? b_sign_eff : a_sign;
        s1_sub_d   = a_sign ^ b_sign_eff;
        s1_valid_d = in_valid;

        s1_special_d    = 1'b0;
        s1_spec_res_d   = '0;
        s1_spec_flags_d = 3'b000;
        if (a_nan || b_nan) begin
            s1_special_d    = 1'b1;
            s1_spec_res_d   = QNAN;
            s1_spec_flags_d = {a_snan | b_snan, 2'b00};
        end else if (a_inf && b_inf) begin
            s1_special_d = 1'b1;
            if (s1_sub_d) begin
                s1_spec_res_d   = QNAN;
                s1_spec_flags_d = 3'b100;
            end else begin
                s1_spec_res_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (a_inf) begin
            s1_special_d  = 1'b1;
            s1_spec_res_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_special_d  = 1'b1;
            s1_spec_res_d = {b_sign_eff, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    always_comb begin
        s2_valid_d      = s1_valid_q;
        s2_sign_d       = s1_sign_q;
        s2_sub_d        = s1_sub_q;
        s2_exp_d        = s1_exp_q;
        s2_special_d    = s1_special_q;
        s2_spec_res_d   = s1_spec_res_q;
        s2_spec_flags_d = s1_spec_flags_q;
        // |X| >= |Y| after the swap, so the difference never goes negative.
        if (s1_sub_q) s2_sum_d = {1'b0, s1_mx_q} - {1'b0, s1_my_q};
        else          s2_sum_d = {1'b0, s1_mx_q} + {1'b0, s1_my_q};
    end

    int              e, lz, sh;
    logic [MW-1:0]   nm;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W:0]  mant;
    logic            round_up, inexact;

    always_comb begin
        lz = MW;
        for (int i = 0; i < MW; i++) begin
            if (s2_sum_q[i]) lz = MW - 1 - i;
        end
        e  = int'(s2_exp_q);
        sh = 0;
        if (s2_sum_q[SW-1]) begin
            nm = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
            e  = e + 1;
        end else begin
            // Left shift stops at exponent 1 so tiny results stay subnormal.
            sh = (lz < e - 1) ? lz : e - 1;
            nm = s2_sum_q[MW-1:0] << sh;
            e  = e - sh;
        end
        round_up = nm[2] & (nm[1] | nm[0] | nm[3]);
        inexact  = |nm[2:0];
        rnd      = {1'b0, nm[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        if (rnd[MAN_W+1]) begin
            mant = rnd[MAN_W+1:1];
            e    = e + 1;
        end else begin
            mant = rnd[MAN_W:0];
        end

        out_valid_d = s2_valid_q;
        flags_d     = 3'b000;
        if (s2_special_q) begin
            result_d = s2_spec_res_q;
            flags_d  = s2_spec_flags_q;
        end else if (s2_sum_q == '0) begin
            result_d = {s2_sign_q & ~s2_sub_q, {(W-1){1'b0}}};
        end else if (e >= EXP_MAX) begin
            result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            flags_d  = 3'b011;
        end else begin
            result_d = {s2_sign_q, (mant[MAN_W] ? EXP_W'(e) : {EXP_W{1'b0}}), mant[MAN_W-1:0]};
            flags_d  = {2'b00, inexact};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_special_q <= 1'b0;
            s1_exp_q <= '0; s1_mx_q <= '0; s1_my_q <= '0;
            s1_spec_res_q <= '0; s1_spec_flags_q <= '0;
            s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_sub_q <= 1'b0; s2_special_q <= 1'b0;
            s2_exp_q <= '0; s2_sum_q <= '0;
            s2_spec_res_q <= '0; s2_spec_flags_q <= '0;
            out_valid_q <= 1'b0; result_q <= '0; flags_q <= '0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d;
            s1_special_q <= s1_special_d; s1_exp_q <= s1_exp_d;
            s1_mx_q <= s1_mx_d; s1_my_q <= s1_my_d;
            s1_spec_res_q <= s1_spec_res_d; s1_spec_flags_q <= s1_spec_flags_d;
            s2_valid_q <= s2_valid_d; s2_sign_q <= s2_sign_d; s2_sub_q <= s2_sub_d;
            s2_special_q <= s2_special_d; s2_exp_q <= s2_exp_d; s2_sum_q <= s2_sum_d;
            s2_spec_res_q <= s2_spec_res_d; s2_spec_flags_q <= s2_spec_flags_d;
            out_valid_q <= out_valid_d; result_q <= result_d; flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed bench for fp_add_sub_pipe: latency, rounding, specials, subnormals,
// stall behaviour and mid-flight reset, with hand-computed binary32 results.
module tb_fp_add_sub_pipe;
    logic        clk, rst_n, in_valid, in_ready, op_add, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [2:0]  flags;
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_add(op_add), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Drives one operation and returns the result plus cycles until out_valid.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                          output logic [31:0] res, output logic [2:0] flg, output int lat);
        a = ta; b = tb_v; op_add = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        flg = flags;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset result got %h want 00000000", result); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset flags got %b want 000", flags); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        idle(4);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_basic();
        vec_t v [5];
        logic [31:0] res; logic [2:0] flg; int lat;
        v[0] = '{32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 3'b000};
        v[1] = '{32'h3F800000, 32'h40000000, 1'b0, 32'hBF800000, 3'b000};
        v[2] = '{32'hC0000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000};
        v[3] = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40400000, 3'b000};
        v[4] = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].op, res, flg, lat);
            checks++; if (lat !== 3) begin failures++; $display("FAIL basic[%0d] latency got %0d want 3", i, lat); end
            checks++; if (res !== v[i].r) begin failures++; $display("FAIL basic[%0d] result got %h want %h", i, res, v[i].r); end
            checks++; if (flg !== v[i].f) begin failures++; $display("FAIL basic[%0d] flags got %b want %b", i, flg, v[i].f); end
        end
    endtask

    task automatic test_rounding();
        vec_t v [6];
        logic [31:0] res; logic [2:0] flg; int lat;
        v[0] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 3'b001};
        v[1] = '{32'h3F800001, 32'h33800000, 1'b1, 32'h3F800002, 3'b001};
        v[2] = '{32'h3F800000, 32'h33C00000, 1'b1, 32'h3F800001, 3'b001};
        v[3] = '{32'h3FFFFFFF, 32'h33800000, 1'b1, 32'h40000000, 3'b001};
        v[4] = '{32'h3F800000, 32'h00000001, 1'b1, 32'h3F800000, 3'b001};
        v[5] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F7FFFFF, 3'b000};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].op, res, flg, lat);
            checks++; if (lat !== 3) begin failures++; $display("FAIL round[%0d] latency got %0d want 3", i, lat); end
            checks++; if (res !== v[i].r) begin failures++; $display("FAIL round[%0d] result got %h want %h", i, res, v[i].r); end
            checks++; if (flg !== v[i].f) begin failures++; $display("FAIL round[%0d] flags got %b want %b", i, flg, v[i].f); end
        end
    endtask

    task automatic test_special();
        vec_t v [11];
        logic [31:0] res; logic [2:0] flg; int lat;
        v[0]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 3'b011};
        v[1]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b100};
        v[2]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000};
        v[3]  = '{32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b000};
        v[4]  = '{32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b100};
        v[5]  = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000};
        v[6]  = '{32'h3F800000, 32'h7F800000, 1'b0, 32'hFF800000, 3'b000};
        v[7]  = '{32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 3'b000};
        v[8]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 3'b000};
        v[9]  = '{32'hBF800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
        v[10] = '{32'h7F7FFFFF, 32'h73000000, 1'b1, 32'h7F800000, 3'b011};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].op, res, flg, lat);
            checks++; if (lat !== 3) begin failures++; $display("FAIL special[%0d] latency got %0d want 3", i, lat); end
            checks++; if (res !== v[i].r) begin failures++; $display("FAIL special[%0d] result got %h want %h", i, res, v[i].r); end
            checks++; if (flg !== v[i].f) begin failures++; $display("FAIL special[%0d] flags got %b want %b", i, flg, v[i].f); end
        end
    endtask

    task automatic test_subnormal();
        vec_t v [4];
        logic [31:0] res; logic [2:0] flg; int lat;
        v[0] = '{32'h00800000, 32'h00400000, 1'b0, 32'h00400000, 3'b000};
        v[1] = '{32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 3'b000};
        v[2] = '{32'h00400000, 32'h00400000, 1'b1, 32'h00800000, 3'b000};
        v[3] = '{32'h00800001, 32'h00800000, 1'b0, 32'h00000001, 3'b000};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].op, res, flg, lat);
            checks++; if (lat !== 3) begin failures++; $display("FAIL subnorm[%0d] latency got %0d want 3", i, lat); end
            checks++; if (res !== v[i].r) begin failures++; $display("FAIL subnorm[%0d] result got %h want %h", i, res, v[i].r); end
            checks++; if (flg !== v[i].f) begin failures++; $display("FAIL subnorm[%0d] flags got %b want %b", i, flg, v[i].f); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [10];
        logic [31:0] exp_q [$];
        logic [31:0] held, want;
        int idx, got, cyc;
        v[0] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
        v[1] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h40400000, 3'b000};
        v[2] = '{32'h3F800000, 32'h40400000, 1'b1, 32'h40800000, 3'b000};
        v[3] = '{32'h40800000, 32'h3F800000, 1'b1, 32'h40A00000, 3'b000};
        v[4] = '{32'h40A00000, 32'h3F800000, 1'b1, 32'h40C00000, 3'b000};
        v[5] = '{32'h40C00000, 32'h3F800000, 1'b1, 32'h40E00000, 3'b000};
        v[6] = '{32'h40E00000, 32'h3F800000, 1'b1, 32'h41000000, 3'b000};
        v[7] = '{32'h41000000, 32'h3F800000, 1'b1, 32'h41100000, 3'b000};
        v[8] = '{32'h41100000, 32'h3F800000, 1'b1, 32'h41200000, 3'b000};
        v[9] = '{32'h41200000, 32'h3F800000, 1'b1, 32'h41300000, 3'b000};
        idle(2);
        idx = 0; got = 0; cyc = 0; held = '0;
        while ((idx < 10 || got < 10) && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            #1;
            if (cyc == 4) held = result;
            if (cyc >= 4 && cyc <= 8) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b stall in_ready cyc %0d got %b want 0", cyc, in_ready); end
            end
            if (cyc >= 5 && cyc <= 8) begin
                checks++; if (result !== held || out_valid !== 1'b1) begin failures++; $display("FAIL b2b hold cyc %0d got %h/%b want %h/1", cyc, result, out_valid, held); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b extra result got %h want none", result);
                end else begin
                    want = exp_q.pop_front();
                    if (result !== want) begin failures++; $display("FAIL b2b order[%0d] got %h want %h", got, result, want); end
                end
                got++;
            end
            if (idx < 10) begin
                a = v[idx].a; b = v[idx].b; op_add = v[idx].op; in_valid = 1'b1;
                if (in_ready) begin
                    exp_q.push_back(v[idx].r);
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 10 || exp_q.size() != 0) begin failures++; $display("FAIL b2b count got %0d want 10", got); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic [2:0] flg; int lat;
        logic seen;
        idle(2);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 32'h3F800000; b = 32'h3F800000; op_add = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL midrst result got %h want 00000000", result); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL midrst flags got %b want 000", flags); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst stale out_valid got 1 want 0"); end
        run_op(32'h40000000, 32'h3F800000, 1'b1, res, flg, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL midrst latency got %0d want 3", lat); end
        checks++; if (res !== 32'h40400000) begin failures++; $display("FAIL midrst result got %h want 40400000", res); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op_add = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_special();
        test_subnormal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
